// File: rtl/t03_player_sprite_writer.sv
// rtl/t03_player_sprite_writer.sv - streams a 15x20 player sprite into a shadow buffer and commits it at vblank
module t03_player_sprite_writer #(
    parameter int PIX_W    = 15,
    parameter int PIX_H    = 20,
    parameter int V_COMMIT = 601
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [10:0]                  Hcnt,
    input  logic [10:0]                  Vcnt,
    input  logic [7:0]                   pix_data,
    input  logic                         pix_sof,
    input  logic                         pix_valid,
    output logic                         pix_ready,
    input  logic                         clear,
    output logic [PIX_W*PIX_H*8-1:0]     player,
    output logic                         busy,
    output logic                         commit_done,
    output logic                         drop_err
);

    localparam int          NPIX       = PIX_W * PIX_H;
    localparam logic [8:0]  LAST_IDX   = 9'(NPIX - 1);
    localparam logic [10:0] V_COMMIT_L = 11'(V_COMMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [8:0]              cnt_q;
    logic [8:0]              cnt_d;
    logic [NPIX*8-1:0]       shadow;

    logic                    fire;
    logic                    commit_pt;
    logic                    wr_en;
    logic [8:0]              wr_idx;
    logic [8:0]              wr_rev;
    logic [11:0]             wr_base;
    logic                    clr_en;
    logic                    commit;
    logic                    drop;

    // Ready and busy decode from registered state only, so ready never waits on valid.
    assign pix_ready = (state_q != PEND);
    assign busy      = (state_q != IDLE);
    assign fire      = pix_valid && pix_ready;
    assign commit_pt = (Hcnt == 11'd0) && (Vcnt == V_COMMIT_L);

    // Raster pixel n lives at the top of the bus for n = 0, so the byte slot is reversed.
    assign wr_rev  = LAST_IDX - wr_idx;
    assign wr_base = {wr_rev, 3'b000};

    // Next-state and datapath controls; a fire in IDLE takes priority over clear.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_idx  = 9'd0;
        clr_en  = 1'b0;
        commit  = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    if (pix_sof) begin
                        wr_en   = 1'b1;
                        wr_idx  = 9'd0;
                        cnt_d   = 9'd1;
                        state_d = LOAD;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (clear) begin
                    clr_en  = 1'b1;
                    state_d = PEND;
                end
            end
            LOAD: begin
                if (fire) begin
                    wr_en = 1'b1;
                    if (pix_sof) begin
                        // Restart overwrites from pixel 0; stale bytes remain until rewritten.
                        wr_idx = 9'd0;
                        cnt_d  = 9'd1;
                    end else begin
                        wr_idx = cnt_q;
                        if (cnt_q == LAST_IDX) begin
                            cnt_d   = 9'd0;
                            state_d = PEND;
                        end else begin
                            cnt_d = cnt_q + 9'd1;
                        end
                    end
                end
            end
            PEND: begin
                if (commit_pt) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 9'd0;
            end
        endcase
    end

    // State and pixel counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 9'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Shadow buffer: cleared on request, otherwise one byte written per accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (clr_en) begin
            shadow <= '0;
        end else if (wr_en) begin
            shadow[wr_base +: 8] <= pix_data;
        end
    end

    // Live bus copies the whole shadow at once so the renderer never sees a partial sprite.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            player <= '0;
        end else if (commit) begin
            player <= shadow;
        end
    end

    // Registered one-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_done <= 1'b0;
            drop_err    <= 1'b0;
        end else begin
            commit_done <= commit;
            drop_err    <= drop;
        end
    end

endmodule

// File: tb/tb_t03_player_sprite_writer.sv
// tb/tb_t03_player_sprite_writer.sv - directed self-checking bench for t03_player_sprite_writer
module tb_t03_player_sprite_writer;

    localparam int NPIX = 300;
    localparam int BW   = NPIX * 8;

    logic          clk;
    logic          rst;
    logic [10:0]   Hcnt;
    logic [10:0]   Vcnt;
    logic [7:0]    pix_data;
    logic          pix_sof;
    logic          pix_valid;
    logic          pix_ready;
    logic          clear;
    logic [BW-1:0] player;
    logic          busy;
    logic          commit_done;
    logic          drop_err;

    logic [BW-1:0] exp_bus;
    int            checks;
    int            errors;
    int            d;

    t03_player_sprite_writer dut (
        .clk         (clk),
        .rst         (rst),
        .Hcnt        (Hcnt),
        .Vcnt        (Vcnt),
        .pix_data    (pix_data),
        .pix_sof     (pix_sof),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .clear       (clear),
        .player      (player),
        .busy        (busy),
        .commit_done (commit_done),
        .drop_err    (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gen(input int mode, input int n);
        case (mode)
            0: return 8'((n % 44) + 1);
            1: return 8'((n * 7 + 3) % 256);
            2: return 8'h55;
            3: return 8'hE0;
            4: return (n == 0) ? 8'h11 : 8'hE0;
            5: return 8'(n % 256) ^ 8'h5A;
            6: return (n == 0) ? 8'h77 : 8'h33;
            7: return 8'hAA;
            default: return 8'h00;
        endcase
    endfunction

    function automatic int first_diff(input logic [BW-1:0] a, input logic [BW-1:0] b);
        for (int i = 0; i < NPIX; i++)
            if (a[(NPIX-1-i)*8 +: 8] !== b[(NPIX-1-i)*8 +: 8]) return i;
        return -1;
    endfunction

    task automatic set_exp(input int mode);
        for (int n = 0; n < NPIX; n++) exp_bus[(NPIX-1-n)*8 +: 8] = gen(mode, n);
    endtask

    task automatic stream(input int start, input int count, input int mode, input bit sof_first);
        for (int i = start; i < start + count; i++) begin
            pix_valid = 1'b1;
            pix_data  = gen(mode, i);
            pix_sof   = (i == start) && sof_first;
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic commit_point();
        Hcnt = 11'd0;
        Vcnt = 11'd601;
        @(posedge clk); #1;
        Hcnt = 11'd5;
        Vcnt = 11'd0;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #3 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++; if (player !== '0) begin errors++; $display("FAIL reset_player: got byte0 %h want 00", player[BW-1 -: 8]); end
        checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", pix_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL reset_commit_done: got %b want 0", commit_done); end
        checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL reset_drop_err: got %b want 0", drop_err); end
    endtask

    task automatic test_full_load();
        stream(0, NPIX, 0, 1'b1);
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL full_ready_after_last: got %b want 0", pix_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_after_last: got %b want 1", busy); end
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (player !== '0) begin errors++; $display("FAIL full_precommit_player: got byte0 %h want 00", player[BW-1 -: 8]); end
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL full_pend_ready: got %b want 0", pix_ready); end
        commit_point();
        checks++; if (player[2399:2392] !== 8'd1) begin errors++; $display("FAIL full_byte0: got %h want 01", player[2399:2392]); end
        checks++; if (player[7:0] !== 8'd36) begin errors++; $display("FAIL full_byte299: got %h want 24", player[7:0]); end
        set_exp(0);
        d = first_diff(player, exp_bus);
        checks++; if (d >= 0) begin errors++; $display("FAIL full_bus: byte %0d got %h want %h", d, player[(NPIX-1-d)*8 +: 8], exp_bus[(NPIX-1-d)*8 +: 8]); end
        checks++; if (commit_done !== 1'b1) begin errors++; $display("FAIL full_commit_done_hi: got %b want 1", commit_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_idle: got %b want 0", busy); end
        @(posedge clk); #1;
        checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL full_commit_done_lo: got %b want 0", commit_done); end
    endtask

    task automatic test_commit_during_load();
        do_reset();
        stream(0, 150, 1, 1'b1);
        commit_point();
        checks++; if (player !== '0) begin errors++; $display("FAIL mid_commit_player: got byte0 %h want 00", player[BW-1 -: 8]); end
        checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL mid_commit_done: got %b want 0", commit_done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_commit_busy: got %b want 1", busy); end
        stream(150, 150, 1, 1'b0);
        checks++; if (player !== '0) begin errors++; $display("FAIL mid_pend_player: got byte0 %h want 00", player[BW-1 -: 8]); end
        commit_point();
        set_exp(1);
        d = first_diff(player, exp_bus);
        checks++; if (d >= 0) begin errors++; $display("FAIL mid_final_bus: byte %0d got %h want %h", d, player[(NPIX-1-d)*8 +: 8], exp_bus[(NPIX-1-d)*8 +: 8]); end
    endtask

    task automatic test_restart_sof();
        stream(0, 100, 7, 1'b1);
        stream(0, NPIX, 2, 1'b1);
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL restart_pend: got ready %b want 0", pix_ready); end
        commit_point();
        set_exp(2);
        d = first_diff(player, exp_bus);
        checks++; if (d >= 0) begin errors++; $display("FAIL restart_bus: byte %0d got %h want %h", d, player[(NPIX-1-d)*8 +: 8], exp_bus[(NPIX-1-d)*8 +: 8]); end
    endtask

    task automatic test_drop();
        pix_valid = 1'b1; pix_data = 8'h12; pix_sof = 1'b0;
        @(posedge clk); #1;
        pix_valid = 1'b0;
        checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b want 1", drop_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_state_idle: got busy %b want 0", busy); end
        checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL drop_ready: got %b want 1", pix_ready); end
        @(posedge clk); #1;
        checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL drop_pulse_end: got %b want 0", drop_err); end
        d = first_diff(player, exp_bus);
        checks++; if (d >= 0) begin errors++; $display("FAIL drop_player: byte %0d got %h want %h", d, player[(NPIX-1-d)*8 +: 8], exp_bus[(NPIX-1-d)*8 +: 8]); end
    endtask

    task automatic test_clear();
        clear = 1'b1;
        stream(0, NPIX, 4, 1'b1);
        clear = 1'b0;
        commit_point();
        set_exp(4);
        d = first_diff(player, exp_bus);
        checks++; if (d >= 0) begin errors++; $display("FAIL clear_in_load_bus: byte %0d got %h want %h", d, player[(NPIX-1-d)*8 +: 8], exp_bus[(NPIX-1-d)*8 +: 8]); end
        stream(0, NPIX, 3, 1'b1);
        commit_point();
        set_exp(3);
        d = first_diff(player, exp_bus);
        checks++; if (d >= 0) begin errors++; $display("FAIL clear_e0_bus: byte %0d got %h want %h", d, player[(NPIX-1-d)*8 +: 8], exp_bus[(NPIX-1-d)*8 +: 8]); end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL clear_pend_ready: got %b want 0", pix_ready); end
        checks++; if (player[BW-1 -: 8] !== 8'hE0) begin errors++; $display("FAIL clear_precommit: got %h want e0", player[BW-1 -: 8]); end
        commit_point();
        checks++; if (player !== '0) begin errors++; $display("FAIL clear_player: got byte0 %h want 00", player[BW-1 -: 8]); end
        checks++; if (commit_done !== 1'b1) begin errors++; $display("FAIL clear_commit_done: got %b want 1", commit_done); end
    endtask

    task automatic test_backpressure_reset();
        stream(0, NPIX, 5, 1'b1);
        pix_valid = 1'b1; pix_data = 8'h77; pix_sof = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++; if (pix_ready !== 1'b0 || busy !== 1'b1 || drop_err !== 1'b0) begin
                errors++; $display("FAIL bp_hold_%0d: got ready %b busy %b drop %b want 0 1 0", i, pix_ready, busy, drop_err);
            end
        end
        commit_point();
        set_exp(5);
        d = first_diff(player, exp_bus);
        checks++; if (d >= 0) begin errors++; $display("FAIL bp_commit_bus: byte %0d got %h want %h", d, player[(NPIX-1-d)*8 +: 8], exp_bus[(NPIX-1-d)*8 +: 8]); end
        @(posedge clk); #1;
        pix_valid = 1'b0; pix_sof = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_held_accepted: got busy %b want 1", busy); end
        stream(1, NPIX - 1, 6, 1'b0);
        commit_point();
        set_exp(6);
        d = first_diff(player, exp_bus);
        checks++; if (d >= 0) begin errors++; $display("FAIL bp_no_loss_bus: byte %0d got %h want %h", d, player[(NPIX-1-d)*8 +: 8], exp_bus[(NPIX-1-d)*8 +: 8]); end
        stream(0, NPIX, 1, 1'b1);
        #3 rst = 1'b1;
        #1;
        checks++; if (player !== '0) begin errors++; $display("FAIL rst_player: got byte0 %h want 00", player[BW-1 -: 8]); end
        checks++; if (pix_ready !== 1'b1 || busy !== 1'b0 || commit_done !== 1'b0 || drop_err !== 1'b0) begin
            errors++; $display("FAIL rst_outputs: got ready %b busy %b cd %b drop %b want 1 0 0 0", pix_ready, busy, commit_done, drop_err);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        commit_point();
        checks++; if (player !== '0) begin errors++; $display("FAIL rst_after_commit: got byte0 %h want 00", player[BW-1 -: 8]); end
        checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL rst_commit_done: got %b want 0", commit_done); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; Hcnt = 11'd5; Vcnt = 11'd0;
        pix_data = 8'h00; pix_sof = 1'b0; pix_valid = 1'b0; clear = 1'b0;
        exp_bus = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_full_load();
        test_commit_during_load();
        test_restart_sof();
        test_drop();
        test_clear();
        test_backpressure_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
